// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAISE    = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } state_e;

  localparam int unsigned ACK_TIMEOUT_DEF = 16;
  localparam logic [15:0] VEC_BASE_DEF    = 16'h0000;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; valid when any bit is set.
module irq_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-capturing, maskable, fixed-priority interrupt controller with an
// acknowledge timeout that re-raises the same vector.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned  N_IRQ       = 4,
  parameter int unsigned  W           = 16,
  parameter logic [W-1:0] VEC_BASE    = W'(VEC_BASE_DEF),
  parameter int unsigned  ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             int_ack,
  input  logic             rti,
  output logic             interrupt,
  output logic [W-1:0]     vec_addr,
  output logic [N_IRQ-1:0] pending,
  output logic             busy
);

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state, state_nxt;
  logic [N_IRQ-1:0]   prev_req;
  logic [N_IRQ-1:0]   mask;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   clr_vec;
  logic [IDX_W-1:0]   active;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic [CNT_W-1:0]   cnt;
  logic               ack_clr;
  logic               interrupt_nxt;
  logic               busy_nxt;

  irq_prio_enc #(
    .N     (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (pending & mask),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign rise    = irq_req & ~prev_req;
  assign ack_clr = (state == WAIT_ACK) && int_ack;
  assign clr_vec = ack_clr ? (N_IRQ'(1) << active) : '0;

  // Request capture and mask; an ack clear overrides a same-cycle edge on the active line.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_req <= '0;
      pending  <= '0;
      mask     <= '1;
    end else begin
      prev_req <= irq_req;
      pending  <= (pending | rise) & ~clr_vec;
      if (mask_wr) begin
        mask <= mask_data;
      end
    end
  end

  // Next state and registered-output inputs.
  always_comb begin
    state_nxt     = state;
    interrupt_nxt = 1'b0;
    busy_nxt      = 1'b0;
    case (state)
      IDLE:     if (sel_valid) state_nxt = RAISE;
      RAISE:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (int_ack) begin
          state_nxt = SERVICE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RAISE;
        end
      end
      SERVICE:  if (rti) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    interrupt_nxt = (state_nxt == RAISE);
    busy_nxt      = (state_nxt != IDLE);
  end

  // State, active vector, timeout counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      active    <= '0;
      cnt       <= '0;
      interrupt <= 1'b0;
      busy      <= 1'b0;
      vec_addr  <= VEC_BASE;
    end else begin
      state     <= state_nxt;
      interrupt <= interrupt_nxt;
      busy      <= busy_nxt;
      if (state == IDLE && sel_valid) begin
        active   <= sel_idx;
        vec_addr <= VEC_BASE + (W'(sel_idx) << 1);
      end
      if (state == RAISE) begin
        cnt <= '0;
      end else if (state == WAIT_ACK && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl at default parameters.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_req;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic       int_ack;
  logic       rti;
  logic       interrupt;
  logic [15:0] vec_addr;
  logic [3:0] pending;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] vec;
    int          lat;
  } exp_t;

  exp_t sb[$];

  irq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_req   (irq_req),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .int_ack   (int_ack),
    .rti       (rti),
    .interrupt (interrupt),
    .vec_addr  (vec_addr),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_irq(input logic [15:0] vec, input int lat);
    exp_t e;
    e.vec = vec;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Step until interrupt shows, then score latency and vector against the queue head.
  task automatic wait_irq(input string tag);
    exp_t e;
    int   k;
    bit   seen;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return;
    end
    e    = sb.pop_front();
    k    = 0;
    seen = 1'b0;
    while (!seen && k < e.lat + 4) begin
      step(1);
      k++;
      seen = interrupt;
    end
    check({tag, "_lat"}, k, e.lat);
    check({tag, "_vec"}, vec_addr, e.vec);
  endtask

  // From RAISE: ack, check pending, return, check idle.
  task automatic service(input string tag, input logic [3:0] exp_pend);
    step(1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    check({tag, "_pend_ack"}, pending, exp_pend);
    check({tag, "_busy_svc"}, busy, 1);
    rti = 1'b1;
    step(1);
    rti = 1'b0;
    check({tag, "_busy_rti"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_req = '0; mask_wr = 1'b0; mask_data = '0; int_ack = 1'b0; rti = 1'b0;
    step(2);
    check("rst_int", interrupt, 0);
    check("rst_busy", busy, 0);
    check("rst_vec", vec_addr, 16'h0000);
    check("rst_pend", pending, 0);
    rst = 1'b0;
    step(1);

    // Single pulse on line 2.
    irq_req = 4'b0100;
    step(1);
    irq_req = 4'b0000;
    check("p2_pend", pending, 4'b0100);
    push_irq(16'h0004, 1);
    wait_irq("p2");
    check("p2_busy", busy, 1);
    step(1);
    check("p2_one_cycle", interrupt, 0);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    check("p2_pend_clr", pending, 0);
    rti = 1'b1;
    step(1);
    rti = 1'b0;
    check("p2_idle", busy, 0);

    // Simultaneous edges on lines 3 and 1.
    irq_req = 4'b1010;
    step(1);
    irq_req = 4'b0000;
    push_irq(16'h0002, 1);
    wait_irq("pr_first");
    service("pr_first", 4'b1000);
    push_irq(16'h0006, 1);
    wait_irq("pr_second");
    service("pr_second", 4'b0000);

    // Masked line 0 latches but does not raise; unmasking raises it.
    int_ack = 1'b1;
    mask_wr = 1'b1; mask_data = 4'b1110;
    step(1);
    mask_wr = 1'b0; int_ack = 1'b0;
    check("ack_idle_ignored", busy, 0);
    irq_req = 4'b0001;
    step(1);
    irq_req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("mask_no_int", interrupt, 0);
    end
    check("mask_pend", pending, 4'b0001);
    check("mask_busy", busy, 0);
    mask_wr = 1'b1; mask_data = 4'b1111;
    step(1);
    mask_wr = 1'b0;
    push_irq(16'h0000, 1);
    wait_irq("unmask");
    service("unmask", 4'b0000);

    // Withheld ack: re-raise every 17 cycles with the same vector.
    irq_req = 4'b0100;
    step(1);
    irq_req = 4'b0000;
    push_irq(16'h0004, 1);
    wait_irq("to_0");
    push_irq(16'h0004, 17);
    wait_irq("to_1");
    push_irq(16'h0004, 17);
    wait_irq("to_2");
    service("to", 4'b0000);

    // Reset during WAIT_ACK with two pending lines.
    irq_req = 4'b0101;
    step(1);
    irq_req = 4'b0000;
    push_irq(16'h0000, 1);
    wait_irq("rw");
    step(1);
    check("rw_pend", pending, 4'b0101);
    rti = 1'b1;
    step(1);
    rti = 1'b0;
    check("rw_rti_ignored", busy, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rw_pend0", pending, 0);
    check("rw_busy0", busy, 0);
    check("rw_int0", interrupt, 0);
    check("rw_vec0", vec_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rw_quiet", interrupt, 0);
    end

    // Edge on line 1 during service of line 0 waits for rti.
    irq_req = 4'b0001;
    step(1);
    irq_req = 4'b0000;
    push_irq(16'h0000, 1);
    wait_irq("nest0");
    step(1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    irq_req = 4'b0010;
    step(1);
    irq_req = 4'b0000;
    check("nest_pend", pending, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("nest_no_int", interrupt, 0);
    end
    rti = 1'b1;
    step(1);
    rti = 1'b0;
    push_irq(16'h0002, 1);
    wait_irq("nest1");
    service("nest1", 4'b0000);

    // Ack coinciding with a new edge on the active line and on another line.
    irq_req = 4'b0001;
    step(1);
    irq_req = 4'b0000;
    push_irq(16'h0000, 1);
    wait_irq("race");
    step(1);
    irq_req = 4'b0011;
    int_ack = 1'b1;
    step(1);
    irq_req = 4'b0000;
    int_ack = 1'b0;
    check("race_pend", pending, 4'b0010);
    rti = 1'b1;
    step(1);
    rti = 1'b0;
    push_irq(16'h0002, 1);
    wait_irq("race1");
    service("race1", 4'b0000);

    // Line held high through reset counts as an edge afterwards.
    rst = 1'b1;
    irq_req = 4'b1000;
    step(2);
    rst = 1'b0;
    push_irq(16'h0006, 2);
    wait_irq("hold");
    irq_req = 4'b0000;
    service("hold", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4: number of external interrupt request lines.
REQ-002 Parameter W, default 16: data-path width of vec_addr.
REQ-003 Parameter VEC_BASE, default 16'h0000: base address of the vector table.
REQ-004 Parameter ACK_TIMEOUT, default 16: cycles to wait for int_ack before re-raising.
REQ-005 Reset is synchronous and active-high; the block runs on one clock.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 irq_req  input  N_IRQ  external level requests, already synchronous to clk.
REQ-009 mask_wr  input  1  load mask register from mask_data this cycle.
REQ-010 mask_data  input  N_IRQ  new mask value; bit=1 enables the line.
REQ-011 int_ack  input  1  processor accepted the interrupt (PC/flags saved); 1-cycle pulse.
REQ-012 rti  input  1  processor executed return-from-interrupt; 1-cycle pulse.
REQ-013 interrupt  output  1  1-cycle pulse to the processor interrupt input.
REQ-014 vec_addr  output  W  VEC_BASE + 2*active index; valid from the interrupt pulse until rti.
REQ-015 pending  output  N_IRQ  latched, not-yet-serviced requests.
REQ-016 busy  output  1  high while any state other than IDLE is held.

Function
REQ-017 Rising-edge detect per line: a line is captured into pending when irq_req goes 0->1 (registered previous value).
REQ-018 The mask gates selection only; masked edges still latch into pending.
REQ-019 Selection uses fixed priority, lowest index highest, over (pending & mask).
REQ-020 FSM states: IDLE, RAISE, WAIT_ACK, SERVICE.
REQ-021 IDLE->RAISE when (pending & mask) != 0; the selected index is registered as active.
REQ-022 In RAISE, interrupt is high for exactly one cycle, then the FSM enters WAIT_ACK and the timeout counter is cleared.
REQ-023 WAIT_ACK->SERVICE on int_ack, which clears pending[active] in the same edge.
REQ-024 WAIT_ACK->RAISE when the counter reaches ACK_TIMEOUT-1 without int_ack; this re-pulses interrupt with the same active index.
REQ-025 SERVICE->IDLE on rti; no nesting, so new edges only latch into pending while in SERVICE.
REQ-026 Latency: an edge on an unmasked line in IDLE produces the interrupt pulse 2 cycles later (capture cycle, then RAISE).
REQ-027 Simultaneous edge on line k and int_ack for active line k: the ack clear wins, and the edge is lost only if k == active.
REQ-028 Simultaneous mask_wr and selection: the new mask takes effect the next cycle.
REQ-029 int_ack outside WAIT_ACK and rti outside SERVICE are ignored.
REQ-030 The timeout counter is $clog2(ACK_TIMEOUT) bits wide and saturates rather than wrapping.

Reset
REQ-031 On rst: state=IDLE, pending=0, mask=all ones, previous-request register=0, counter=0, active=0.
REQ-032 On rst, outputs are interrupt=0, busy=0, vec_addr=VEC_BASE.
REQ-033 rst mid-operation (any state) discards the active interrupt and all pending requests.
REQ-034 The first edge detection after reset compares against 0, so a line held high through reset counts as an edge.

Structure
REQ-035 A shared package holds the FSM state enum, ACK_TIMEOUT default, and VEC_BASE default.
REQ-036 One sub-module, irq_prio_enc (combinational, N_IRQ-input), returns the index plus a valid flag.
REQ-037 RTL is 120-400 lines; no latches, single always block per register group.

Verification
REQ-038 Pulse irq_req[2] for 1 cycle, mask all ones -> interrupt pulses 2 cycles later, vec_addr=0x0004; int_ack -> pending[2]=0; rti -> busy=0.
REQ-039 Rising edges on irq_req[3] and irq_req[1] in the same cycle -> vec_addr=0x0002 first; after rti, a second pulse with vec_addr=0x0006.
REQ-040 mask=4'b1110, edge on line 0 -> no interrupt and pending[0]=1; then mask_wr with 4'b1111 -> interrupt pulses 2 cycles later, vec_addr=0x0000.
REQ-041 Withhold int_ack -> interrupt re-pulses every ACK_TIMEOUT+1 cycles (17 by default) with an unchanged vec_addr.
REQ-042 Assert rst during WAIT_ACK with pending=4'b0101 -> next cycle pending=0, busy=0, interrupt=0.
REQ-043 Edge on line 1 during SERVICE of line 0 -> no pulse until rti; pulse 2 cycles after rti with vec_addr=0x0002.
